// File: rtl/mem_port_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
// Other arbiters in the design also use the owner encoding.
package mem_port_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    // Access counter width; it holds LAT-1, and LAT is at most 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bit value doubles as the picker grant: 0 = fetch, 1 = memory stage.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // A contended grant goes to the requester that did not win last time.
    function automatic logic rr_choose(input logic req_if, input logic req_mem,
                                       input logic last_winner);
        if (req_if && req_mem) begin
            return ~last_winner;
        end
        return req_mem;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin picker. It is purely combinational, so the
// caller decides when a grant is taken.
module rr_pick2
    import mem_port_pkg::*;
(
    input  logic req_if,
    input  logic req_mem,
    input  logic last_winner,
    output logic grant,
    output logic valid
);

    assign valid = req_if | req_mem;
    assign grant = rr_choose(req_if, req_mem, last_winner);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency word memory between instruction fetch and the
// memory stage. Each access takes IDLE -> ACCESS (LAT cycles) -> DONE.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int LAT = 4,
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF
)
(
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,

    input  logic          mem_req,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_done,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_err,

    output logic          ram_en,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t           state_reg;
    owner_t           owner_reg;
    logic             last_winner_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [AW-1:0]    addr_reg;
    logic [DW-1:0]    wdata_reg;
    logic             wr_reg;

    logic             pick_grant;
    logic             pick_valid;

    rr_pick2 u_pick (
        .req_if      (if_req),
        .req_mem     (mem_req),
        .last_winner (last_winner_reg),
        .grant       (pick_grant),
        .valid       (pick_valid)
    );

    // The memory sees only the latched request. Requester inputs reach it
    // only through the grant registers.
    assign ram_addr  = addr_reg;
    assign ram_wdata = wdata_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            owner_reg       <= OWN_IF;
            last_winner_reg <= 1'b0;
            cnt_reg         <= '0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            wr_reg          <= 1'b0;
            ram_en          <= 1'b0;
            ram_wr          <= 1'b0;
            if_done         <= 1'b0;
            if_err          <= 1'b0;
            if_rdata        <= '0;
            mem_done        <= 1'b0;
            mem_err         <= 1'b0;
            mem_rdata       <= '0;
        end else begin
            // done and err are single-cycle, so they clear unless set below.
            if_done  <= 1'b0;
            if_err   <= 1'b0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        owner_reg       <= owner_t'(pick_grant);
                        last_winner_reg <= pick_grant;
                        addr_reg        <= pick_grant ? mem_addr : if_addr;
                        wdata_reg       <= pick_grant ? mem_wdata : '0;
                        wr_reg          <= pick_grant & mem_wr;
                        cnt_reg         <= CNT_LOAD;
                        ram_en          <= 1'b1;
                        ram_wr          <= pick_grant & mem_wr;
                        state_reg       <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt_reg == '0) begin
                        ram_en    <= 1'b0;
                        ram_wr    <= 1'b0;
                        state_reg <= DONE;
                        if (owner_reg == OWN_MEM) begin
                            mem_done <= 1'b1;
                            mem_err  <= ram_err;
                            if (!wr_reg) begin
                                mem_rdata <= ram_rdata;
                            end
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= ram_err;
                            if_rdata <= ram_rdata;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random transactions against a transaction-level model of
// the arbiter: grant order, access window, latency, rdata and err.
module tb_mem_port_arbiter;

    localparam int LAT = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          mem_req = 1'b0;
    logic          mem_wr = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          mem_err;
    logic          ram_en;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_err = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference state: who won last, and what each rdata port should show.
    logic          last_w = 1'b0;
    logic [DW-1:0] exp_if_rd = '0;
    logic [DW-1:0] exp_mem_rd = '0;

    mem_port_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_err   (ram_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_done"}, if_done, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_if_err"}, if_err, 0);
        chk({tag, "_mem_done"}, mem_done, 0);
        chk({tag, "_mem_rdata"}, mem_rdata, 0);
        chk({tag, "_mem_err"}, mem_err, 0);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_wr"}, ram_wr, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
    endtask

    task automatic scramble_inputs();
        if_req    = 1'($urandom);
        if_addr   = AW'($urandom);
        mem_req   = 1'($urandom);
        mem_wr    = 1'($urandom);
        mem_addr  = AW'($urandom);
        mem_wdata = DW'($urandom);
        ram_rdata = DW'($urandom);
        ram_err   = 1'($urandom);
    endtask

    // Called in an IDLE cycle. Returns in the first IDLE cycle after DONE,
    // with the requests still held.
    task automatic do_txn(input logic ir, input logic mr, input logic wr,
                          input logic [AW-1:0] ia, input logic [AW-1:0] ma,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                          input logic er);
        logic          win;
        logic [AW-1:0] ea;
        logic          ew;
        win = (ir && mr) ? ~last_w : mr;
        ea  = win ? ma : ia;
        ew  = win & wr;
        if_req = ir; mem_req = mr; mem_wr = wr;
        if_addr = ia; mem_addr = ma; mem_wdata = wd;
        ram_rdata = DW'($urandom); ram_err = 1'($urandom);
        for (int c = 1; c <= LAT; c++) begin
            tick();
            if (c == 1) begin
                if_addr = AW'($urandom); mem_addr = AW'($urandom);
                mem_wdata = DW'($urandom); mem_wr = 1'($urandom);
            end
            if (c == LAT) begin
                ram_rdata = rd; ram_err = er;
            end else begin
                ram_rdata = DW'($urandom); ram_err = 1'($urandom);
            end
            chk("acc_ram_en", ram_en, 1);
            chk("acc_ram_wr", ram_wr, ew);
            chk("acc_ram_addr", ram_addr, ea);
            if (ew) chk("acc_ram_wdata", ram_wdata, wd);
            chk("acc_if_done", if_done, 0);
            chk("acc_mem_done", mem_done, 0);
        end
        tick();
        ram_rdata = DW'($urandom); ram_err = 1'($urandom);
        last_w = win;
        if (!ew) begin
            if (win) exp_mem_rd = rd;
            else     exp_if_rd = rd;
        end
        chk("done_ram_en", ram_en, 0);
        chk("done_if_done", if_done, !win);
        chk("done_mem_done", mem_done, win);
        chk("done_if_err", if_err, !win && er);
        chk("done_mem_err", mem_err, win && er);
        chk("done_if_rdata", if_rdata, exp_if_rd);
        chk("done_mem_rdata", mem_rdata, exp_mem_rd);
        tick();
        chk("post_if_done", if_done, 0);
        chk("post_mem_done", mem_done, 0);
        chk("post_if_err", if_err, 0);
        chk("post_mem_err", mem_err, 0);
        chk("post_ram_en", ram_en, 0);
        $display("txn owner=%s wr=%0d addr=%h rdata=%h err=%0d if_rdata=%h mem_rdata=%h",
                 win ? "MEM" : "IF", ew, ea, rd, er, if_rdata, mem_rdata);
    endtask

    task automatic idle_cycles(input int n);
        if_req = 1'b0; mem_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_ram_en", ram_en, 0);
            chk("idle_if_done", if_done, 0);
            chk("idle_mem_done", mem_done, 0);
        end
    endtask

    initial begin
        logic          ir, mr, wr, er;
        logic [AW-1:0] ia, ma;
        logic [DW-1:0] wd, rd;
        int            pat;

        // Random inputs while reset is held leave every output at zero.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            scramble_inputs();
            tick();
        end
        chk_all_zero("rst_hold");
        if_req = 1'b0; mem_req = 1'b0; ram_err = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_release_ram_en", ram_en, 0);
        chk("rst_release_mem_done", mem_done, 0);

        // MEM read, then MEM write; the write must not disturb mem_rdata.
        do_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        chk("t2_mem_rdata", mem_rdata, 16'hBEEF);
        idle_cycles(1);
        do_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 16'h1234, 16'h5A5A, 1'b0);
        chk("t3_mem_rdata_hold", mem_rdata, 16'hBEEF);
        idle_cycles(1);

        // IF read that ends in an error; the last grant is then IF.
        do_txn(1'b1, 1'b0, 1'b0, 16'h0101, 16'h0000, 16'h0000, 16'hCAFE, 1'b1);
        chk("t5_if_rdata", if_rdata, 16'hCAFE);
        idle_cycles(1);

        // Both requesters held throughout, so grants alternate MEM, IF, MEM.
        do_txn(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0300, 16'h0000, 16'h1111, 1'b0);
        do_txn(1'b1, 1'b1, 1'b0, 16'h0204, 16'h0304, 16'h0000, 16'h2222, 1'b0);
        do_txn(1'b1, 1'b1, 1'b1, 16'h0208, 16'h0308, 16'h7777, 16'h3333, 1'b0);
        chk("t4_if_rdata", if_rdata, 16'h2222);
        chk("t4_mem_rdata", mem_rdata, 16'h1111);
        idle_cycles(1);

        // An asynchronous reset partway through a MEM read abandons the access.
        if_req = 1'b0; mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 16'h0040;
        tick();
        tick();
        chk("t6_pre_ram_en", ram_en, 1);
        rst = 1'b0;
        #1;
        chk_all_zero("t6_async");
        last_w = 1'b0; exp_if_rd = '0; exp_mem_rd = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_mem_done", mem_done, 0);
            chk("t6_hold_ram_en", ram_en, 0);
        end
        rst = 1'b1;
        do_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 16'h4444, 1'b0);
        idle_cycles(1);

        // Random transactions with random idle gaps between them.
        for (int n = 0; n < 40; n++) begin
            pat = int'($urandom_range(0, 2));
            ir  = (pat != 1);
            mr  = (pat != 0);
            wr  = 1'($urandom);
            ia  = AW'($urandom);
            ma  = AW'($urandom);
            wd  = DW'($urandom);
            rd  = DW'($urandom);
            er  = ($urandom_range(0, 3) == 0);
            do_txn(ir, mr, wr, ia, ma, wd, rd, er);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

endmodule
